// File: rtl/mem_access_sequencer_if.sv
// Bundle of request, response and memory-port signals for mem_access_sequencer.
// slave  : the sequencer's view (accepts requests, drives the memory port).
// master : the requester/memory side's view.
interface mem_access_sequencer_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_ctrl;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [2:0]        mem_ctrl;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wdata, mem_we, mem_ctrl
    );

    modport master (
        output req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wdata, mem_we, mem_ctrl
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: turns byte/half/word loads and stores into word-aligned,
// full-word memory accesses. Sub-word and misaligned stores become
// read-modify-write; accesses crossing a word boundary are split in two.
// Optional build macro: MISALIGN_TRAP_EN -- reject non-naturally-aligned
// accesses with rsp_err instead of splitting them.
module mem_access_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_access_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_WR0  = 3'd3,
        S_WR1  = 3'd4,
        S_RESP = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       w0_q, w0_d;
    logic [31:0]       w1_q, w1_d;
    logic              err_q, err_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;

    logic              trap_s;
    logic              span_s;
    logic [7:0]        lanes_s;
    logic [63:0]       wshift_s;
    logic [ADDR_W-1:0] a0_s, a1_s;

    // Byte lanes touched across the two-word window {w1, w0}.
    function automatic logic [7:0] lanes_of(input logic [2:0] ctrl, input logic [1:0] off);
        logic [3:0] m;
        case (ctrl[1:0])
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return {4'b0000, m} << off;
    endfunction

    function automatic logic ctrl_ok(input logic we, input logic [2:0] ctrl);
        case ({we, ctrl})
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101: return 1'b1;
            4'b1000, 4'b1001, 4'b1010:                   return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] ctrl, input logic [1:0] off);
        case (ctrl[1:0])
            2'b01:   return off[0];
            2'b10:   return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Replace the selected byte lanes of old_w with those of new_w.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  lanes);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = lanes[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return r;
    endfunction

    // Truncate the right-aligned window to the access size and extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] ctrl, input logic [31:0] lw);
        case (ctrl[1:0])
            2'b00:   return ctrl[2] ? {24'h000000, lw[7:0]}  : {{24{lw[7]}},  lw[7:0]};
            2'b01:   return ctrl[2] ? {16'h0000,   lw[15:0]} : {{16{lw[15]}}, lw[15:0]};
            default: return lw;
        endcase
    endfunction

    // Next-state, request capture and next values of every registered output.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        ctrl_d  = ctrl_q;
        wdata_d = wdata_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        err_d   = err_q;
`ifdef MISALIGN_TRAP_EN
        trap_s  = misaligned(bus.req_ctrl, bus.req_addr[1:0]);
`else
        trap_s  = 1'b0;
`endif
        span_s  = (lanes_of(ctrl_q, addr_q[1:0]) >> 4) != 8'h00;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    we_d    = bus.req_we;
                    ctrl_d  = bus.req_ctrl;
                    wdata_d = bus.req_wdata;
                    if (!ctrl_ok(bus.req_we, bus.req_ctrl) || trap_s) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (bus.req_we && (bus.req_ctrl == 3'b010) && (bus.req_addr[1:0] == 2'b00)) begin
                        err_d   = 1'b0;
                        state_d = S_WR0;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_RD0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD0: begin
                w0_d = bus.mem_rdata;
                if (span_s)    state_d = S_RD1;
                else if (we_q) state_d = S_WR0;
                else           state_d = S_RESP;
            end
            S_RD1: begin
                w1_d = bus.mem_rdata;
                if (we_q) state_d = S_WR0;
                else      state_d = S_RESP;
            end
            S_WR0: begin
                if (span_s) state_d = S_WR1;
                else        state_d = S_RESP;
            end
            S_WR1:   state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        lanes_s  = lanes_of(ctrl_d, addr_d[1:0]);
        wshift_s = {32'h00000000, wdata_d} << {addr_d[1:0], 3'b000};
        a0_s     = {addr_d[ADDR_W-1:2], 2'b00};
        a1_s     = a0_s + ADDR_W'(4);

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        mem_we_d    = (state_d == S_WR0) || (state_d == S_WR1);
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_d)
            S_RD0:  mem_addr_d = a0_s;
            S_RD1:  mem_addr_d = a1_s;
            S_WR0: begin
                mem_addr_d  = a0_s;
                mem_wdata_d = merge_bytes(w0_d, wshift_s[31:0], lanes_s[3:0]);
            end
            S_WR1: begin
                mem_addr_d  = a1_s;
                mem_wdata_d = merge_bytes(w1_d, wshift_s[63:32], lanes_s[7:4]);
            end
            S_RESP: begin
                rsp_err_d = err_d;
                if (err_d || we_d) rsp_rdata_d = 32'h00000000;
                else rsp_rdata_d = load_extend(ctrl_d, 32'({w1_d, w0_d} >> {addr_d[1:0], 3'b000}));
            end
            default: mem_addr_d = mem_addr_q;
        endcase
    end

    // State, request and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            ctrl_q      <= 3'b000;
            wdata_q     <= 32'h00000000;
            w0_q        <= 32'h00000000;
            w1_q        <= 32'h00000000;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h00000000;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h00000000;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            ctrl_q      <= ctrl_d;
            wdata_q     <= wdata_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign bus.req_ready = req_ready_q & ~rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_ctrl  = 3'b010;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Testbench for mem_access_sequencer: directed test-plan cases, a mid-store
// reset, then random requests checked by a scoreboard against a byte-level
// reference memory model.
module tb_mem_access_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_access_sequencer_if #(.ADDR_W(32)) bus ();

    mem_access_sequencer #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory seen by the DUT: 256 words, aliased on address bits [9:2].
    logic [31:0] tb_mem [256];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_idx = 8'h00;
    logic [31:0] bd_data = 32'h0;

    always @(posedge clk) begin
        if (bd_we) tb_mem[bd_idx] <= bd_data;
        else if (bus.mem_we) tb_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = tb_mem[bus.mem_addr[9:2]];

    // Reference: flat byte memory with the same aliasing.
    logic [7:0] ref_mem [1024];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  lat;
        logic [7:0]  writes;
        logic [31:0] h;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural result of one request; updates the reference memory for stores.
    function automatic exp_t model(input logic we, input logic [2:0] ctrl,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int          size;
        int          off;
        logic        ok;
        logic [31:0] v;
        logic [31:0] ba;
        e = '0;
        off  = int'(addr[1:0]);
        size = (ctrl[1:0] == 2'd0) ? 1 : ((ctrl[1:0] == 2'd1) ? 2 : 4);
        ok   = we ? (ctrl inside {3'd0, 3'd1, 3'd2}) : (ctrl inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef MISALIGN_TRAP_EN
        if ((off % size) != 0) ok = 1'b0;
`endif
        if (!ok) begin
            e.err = 1'b1;
            e.lat = 8'd1;
            return e;
        end
        if (we) begin
            for (int k = 0; k < size; k++) begin
                ba = addr + 32'(k);
                ref_mem[ba[9:0]] = wdata[8*k +: 8];
            end
            e.writes = (off + size > 4) ? 8'd2 : 8'd1;
            if (size == 4 && off == 0) e.lat = 8'd2;
            else if (off + size > 4)   e.lat = 8'd5;
            else                       e.lat = 8'd3;
        end else begin
            v = 32'h0;
            for (int k = 0; k < size; k++) begin
                ba = addr + 32'(k);
                v = v | (32'(ref_mem[ba[9:0]]) << (8 * k));
            end
            if (!ctrl[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFFFFFF << (8 * size));
            e.rdata = v;
            e.lat   = (off + size > 4) ? 8'd3 : 8'd2;
        end
        return e;
    endfunction

    // Monitor: counts memory writes per transaction and checks each response.
    int wr_seen = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            wr_seen = 0;
        end else begin
            if (bus.mem_we) begin
                wr_seen++;
                check("mem_addr_aligned", {30'h0, bus.mem_addr[1:0]}, 32'h0);
            end
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp_valid", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_rdata", bus.rsp_rdata, e.rdata);
                    check("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
                    check("latency", 32'(cyc) - e.h + 32'd1, {24'h0, e.lat});
                    check("mem_writes", 32'(wr_seen), {24'h0, e.writes});
                    check("mem_ctrl", {29'h0, bus.mem_ctrl}, 32'h2);
                end
                wr_seen = 0;
            end
        end
    end

    task automatic randomize_idle_inputs();
        bus.req_we    = 1'($urandom);
        bus.req_ctrl  = 3'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
    endtask

    // Present a request (called at a negedge) and return at the negedge after the handshake.
    task automatic issue(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit track);
        exp_t e;
        int   guard;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_ctrl  = ctrl;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            check("req_ready_timeout", 32'h0, 32'h1);
            bus.req_valid = 1'b0;
            return;
        end
        if (track) begin
            e   = model(we, ctrl, addr, wdata);
            e.h = 32'(cyc + 1);
            sb.push_back(e);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        randomize_idle_inputs();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", 32'(sb.size()), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic backdoor(input logic [7:0] idx, input logic [31:0] w);
        bd_we   = 1'b1;
        bd_idx  = idx;
        bd_data = w;
        for (int b = 0; b < 4; b++) ref_mem[{idx, 2'(b)}] = w[8*b +: 8];
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic restore_test_words();
        backdoor(8'h04, 32'h44332211);
        backdoor(8'h05, 32'h88776655);
    endtask

    task automatic check_word(input string name, input logic [31:0] addr, input logic [31:0] exp);
        check(name, tb_mem[addr[9:2]], exp);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  c;
        logic [2:0]  valid_ctrl [5];
        valid_ctrl[0] = 3'd0; valid_ctrl[1] = 3'd1; valid_ctrl[2] = 3'd2;
        valid_ctrl[3] = 3'd4; valid_ctrl[4] = 3'd5;

        bus.req_valid = 1'b0;
        randomize_idle_inputs();
        @(negedge clk);

        // Preload under reset; req_ready must stay low meanwhile.
        check("req_ready_in_reset", {31'h0, bus.req_ready}, 32'h0);
        for (int i = 0; i < 256; i++) backdoor(8'(i), $urandom);
        restore_test_words();
        check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
        check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        rst = 1'b0;
        #1;
        check("req_ready_after_reset", {31'h0, bus.req_ready}, 32'h1);
        @(negedge clk);

        // Test plan 1-3
        issue(1'b0, 3'b000, 32'h17, $urandom, 1'b1);
        issue(1'b0, 3'b100, 32'h17, $urandom, 1'b1);
        issue(1'b0, 3'b010, 32'h12, $urandom, 1'b1);
        issue(1'b1, 3'b000, 32'h11, 32'h000000AB, 1'b1);
        drain();
        check_word("t3_word10", 32'h10, 32'h4433AB11);
        check_word("t3_word14", 32'h14, 32'h88776655);

        // Test plan 4
        restore_test_words();
        issue(1'b1, 3'b010, 32'h13, 32'hDEADBEEF, 1'b1);
        drain();
`ifdef MISALIGN_TRAP_EN
        check_word("t4_word10", 32'h10, 32'h44332211);
        check_word("t4_word14", 32'h14, 32'h88776655);
`else
        check_word("t4_word10", 32'h10, 32'hEF332211);
        check_word("t4_word14", 32'h14, 32'h88DEADBE);
`endif

        // Test plan 5: illegal ctrl codes
        issue(1'b0, 3'b011, 32'h10, $urandom, 1'b1);
        issue(1'b1, 3'b100, 32'h10, $urandom, 1'b1);
        drain();

`ifndef MISALIGN_TRAP_EN
        // Test plan 6: reset lands in WR0 of the spanning store
        restore_test_words();
        issue(1'b1, 3'b010, 32'h13, 32'hDEADBEEF, 1'b0);
        repeat (2) @(negedge clk);
        check("wr0_mem_we", {31'h0, bus.mem_we}, 32'h1);
        check("wr0_mem_addr", bus.mem_addr, 32'h10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_mem[10'h013] = 8'hEF;
        #1;
        check("post_rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        check("post_rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        check("post_rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
        repeat (6) @(negedge clk);
        check_word("t6_word10", 32'h10, 32'hEF332211);
        check_word("t6_word14", 32'h14, 32'h88776655);
`endif

        // Address wrap at the top of the address space
        issue(1'b1, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D, 1'b1);
        issue(1'b0, 3'b001, 32'hFFFFFFFF, $urandom, 1'b1);
        issue(1'b0, 3'b010, 32'hFFFFFFFD, $urandom, 1'b1);

        // Random traffic, back-to-back with occasional gaps
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            else                           a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 4) == 0) c = 3'($urandom);
            else                           c = valid_ctrl[$urandom_range(0, 4)];
            issue(1'($urandom), c, a, $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        // Final memory image against the reference
        for (int i = 0; i < 256; i++) begin
            check("final_mem", tb_mem[i],
                  {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Sits directly upstream of the byte-addressed data memory, between the core's load/store path and the memory port.
- Accepts one load or store request at a time using the memory's 3-bit size/sign control encoding.
- Issues only word-aligned, full-word memory accesses:
  - Sub-word and misaligned stores become read-modify-write sequences. The memory's native sub-word store zero-fills the upper bytes, so it must not be used.
  - Accesses that cross a word boundary are split into two word accesses.
- Returns the assembled, extended load result through a single-cycle response pulse.

Parameters:
- ADDR_W, 32, byte address width; the second-word address wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_ctrl  in  3  000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  request rejected; valid only with rsp_valid.
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 00).
- mem_wdata  out  32  full word to write.
- mem_we  out  1  memory write enable.
- mem_ctrl  out  3  constant 010.
- mem_rdata  in  32  combinational read data for mem_addr.

Behaviour:
- Reset values: state IDLE, req_ready 1 (forced 0 while rst = 1), rsp_valid 0, rsp_rdata 0, rsp_err 0, mem_we 0, mem_addr 0, mem_wdata 0.
- Request registers:
  - Handshake fires when req_valid && req_ready.
  - req_ready = 1 only in IDLE.
  - On handshake, addr, we, ctrl and wdata are captured; inputs are ignored otherwise.
- Derived values:
  - off = addr[1:0].
  - size = 1, 2 or 4 bytes from ctrl.
  - span = (off + size > 4).
  - a0 = addr with [1:0] cleared; a1 = a0 + 4, wrapping.
- Valid ctrl values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Any other value goes IDLE → RESP with rsp_err = 1, no memory access, response at T+1 (T = handshake cycle).
- States: IDLE, RD0, RD1, WR0, WR1, RESP.
- Load path:
  - RD0: mem_addr = a0; capture w0. Go to RD1 if span, else RESP.
  - RD1: mem_addr = a1; capture w1. Go to RESP.
  - RESP: rsp_rdata = ({w1, w0} >> 8*off) truncated to size, then sign- or zero-extended per ctrl.
- Store path:
  - Full word with off = 0: go IDLE → WR0 directly.
  - Otherwise: RD0 (then RD1 if span) → WR0 (then WR1 if span) → RESP.
  - WR0: mem_addr = a0; mem_wdata = w0 with the store bytes merged at byte lanes off..min(3, off+size-1); mem_we = 1.
  - WR1: mem_addr = a1; mem_wdata = w1 with the remaining store bytes in lanes 0..(off+size-5); mem_we = 1.
- Latency (rsp_valid cycle):

| Access | rsp_valid at |
|---|---|
| Aligned load | T+2 |
| Spanning load | T+3 |
| Aligned full-word store | T+2 |
| Non-spanning sub-word or misaligned store | T+3 |
| Spanning store | T+5 |

- RESP:
  - rsp_valid = 1 for exactly one cycle, then IDLE.
  - req_ready returns to 1 in the following cycle; back-to-back throughput is one request per (latency + 1) cycles.
- Output timing:
  - mem_we is high only in WR0 and WR1.
  - rsp_rdata and rsp_err hold their values until the next RESP.
- Reset mid-operation:
  - Next state is IDLE; the in-flight request is abandoned and no rsp_valid is generated.
  - If reset lands between WR0 and WR1, memory is left partially updated; this is permitted.
- Address wrap: a1 for a0 = all-ones minus 3 wraps to 0.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined:
  - Any access not naturally aligned (half with off[0] = 1, word with off ≠ 0) goes IDLE → RESP with rsp_err = 1, rsp_valid at T+1, no memory access.
  - RD1 and WR1 are never entered.
- When undefined: misaligned and spanning accesses are split as described in Behaviour.

Test Plan:
Memory preload: word 0x10 = 0x44332211, word 0x14 = 0x88776655.
1. Load byte at 0x17:
   - ctrl 000 → rsp_rdata 0xFFFFFF88 at T+2.
   - ctrl 100 → 0x00000088 at T+2.
   - Neither access asserts mem_we.
2. Load word at 0x12, ctrl 010 → mem_addr 0x10 then 0x14; rsp_rdata 0x66554433 at T+3.
3. Store byte 0xAB at 0x11, ctrl 000 → word 0x10 = 0x4433AB11, word 0x14 unchanged, rsp_valid at T+3.
4. Store 0xDEADBEEF at 0x13, ctrl 010 → word 0x10 = 0xEF332211, word 0x14 = 0x88DEADBE, rsp_valid at T+5. With MISALIGN_TRAP_EN: rsp_err = 1 at T+1, memory unchanged.
5. Load at 0x10 with ctrl 011, and store with ctrl 100 → rsp_err = 1, rsp_rdata 0, rsp_valid at T+1, mem_we never asserted.
6. Assert rst during WR0 of test 4 → next cycle state IDLE, req_ready 1, no rsp_valid; word 0x10 updated, word 0x14 = 0x88776655.
